// File: rtl/toll_pkg.sv
// Shared definitions for the toll lane scheduler.
// Contents:
//   state_t        - sequencer state encoding, also driven out on currentstate
//   DEFAULT_TAG_W  - default hipass tag width per lane
package toll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int DEFAULT_TAG_W = 5;

endpackage

// File: rtl/toll_rr_arbiter.sv
// Round-robin lane picker for the shared hipass processor.
// It searches the pending vector starting at rr_ptr+1 and wraps modulo LANES,
// so the lane granted last has the lowest priority next time.
// Purely combinational.
// Ports:
//   pending  in   LANES          lanes waiting for service
//   rr_ptr   in   clog2(LANES)   lane granted most recently
//   any_req  out  1              at least one lane is pending
//   grant    out  clog2(LANES)   lane to serve next (valid when any_req)
module toll_rr_arbiter #(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]         pending,
    input  logic [$clog2(LANES)-1:0] rr_ptr,
    output logic                     any_req,
    output logic [$clog2(LANES)-1:0] grant
);

    localparam int IW = $clog2(LANES);

    // cand_idx[k] is the lane examined at search position k (k=0 -> rr_ptr+1).
    logic [IW-1:0]    cand_idx [LANES];
    logic [LANES-1:0] cand_hit;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_cand
        assign cand_idx[gi] = IW'((int'(rr_ptr) + gi + 1) % LANES);
        assign cand_hit[gi] = pending[cand_idx[gi]];
    end

    // Walk from the farthest position back to the nearest so the nearest
    // pending lane is the final assignment.
    always_comb begin
        any_req = |pending;
        grant   = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/toll_lane_scheduler.sv
// Lane sequencer that shares one hipass validation/billing unit among LANES
// toll lanes. Car arrivals are edge-detected per lane and queued as pending
// requests; the shared processor is granted round-robin, the granted lane's
// tag is captured, and the verdict either opens that lane's gate for
// GATE_CYCLES cycles or raises its sticky alarm.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   car           per-lane car-present level
//   hipass        per-lane tags, lane i at [i*TAG_W +: TAG_W], 0 = no tag
//   proc_start    one-cycle start pulse to the shared processor
//   proc_lane     lane currently granted
//   proc_tag      tag captured at grant, stable until the next grant
//   proc_done     verdict valid pulse; proc_ok is the verdict
//   gate_open     per-lane gate raise
//   alarm         per-lane sticky violation flag, cleared by alarm_clr
//   busy          sequencer not idle
//   currentstate  sequencer state encoding
module toll_lane_scheduler
    import toll_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int TAG_W       = DEFAULT_TAG_W,
    parameter int GATE_CYCLES = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         car,
    input  logic [LANES*TAG_W-1:0]   hipass,
    output logic                     proc_start,
    output logic [$clog2(LANES)-1:0] proc_lane,
    output logic [TAG_W-1:0]         proc_tag,
    input  logic                     proc_done,
    input  logic                     proc_ok,
    output logic [LANES-1:0]         gate_open,
    output logic [LANES-1:0]         alarm,
    input  logic [LANES-1:0]         alarm_clr,
    output logic                     busy,
    output logic [1:0]               currentstate
);

    localparam int IW = $clog2(LANES);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT);

    state_t           state_reg, state_next;
    logic [LANES-1:0] car_q_reg;
    logic             armed_reg;
    logic [LANES-1:0] pending_reg, pending_next;
    logic [IW-1:0]    rr_ptr_reg;
    logic [IW-1:0]    proc_lane_reg;
    logic [TAG_W-1:0] proc_tag_reg;
    logic [TW-1:0]    timer_reg, timer_next;
    logic             result_reg, result_next;

    logic             any_req;
    logic [IW-1:0]    grant_idx;
    logic             grant_take;
    logic             release_ok;
    logic             release_fail;
    logic [LANES-1:0] rise;
    logic [LANES-1:0] grant_mask;

    // car_q is zero after reset, so a car already standing in a lane when
    // reset drops would look like a fresh arrival. armed_reg suppresses edge
    // detection for the first cycle out of reset while car_q catches up, so
    // held cars do not re-request.
    assign rise       = car & ~car_q_reg & {LANES{armed_reg}};
    assign grant_mask = grant_take ? (LANES'(1) << grant_idx) : '0;
    // A rise on the lane being granted re-queues it: set wins over clear.
    assign pending_next = (pending_reg & ~grant_mask) | rise;

    toll_rr_arbiter #(
        .LANES (LANES)
    ) u_arbiter (
        .pending (pending_reg),
        .rr_ptr  (rr_ptr_reg),
        .any_req (any_req),
        .grant   (grant_idx)
    );

    always_comb begin
        state_next   = state_reg;
        proc_start   = 1'b0;
        grant_take   = 1'b0;
        timer_next   = timer_reg;
        result_next  = result_reg;
        release_ok   = 1'b0;
        release_fail = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_take = 1'b1;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                timer_next = '0;
                if (proc_tag_reg != '0) begin
                    proc_start = 1'b1;
                    state_next = ST_WAIT;
                end else begin
                    // No tag: never bother the processor, fail directly.
                    result_next = 1'b0;
                    state_next  = ST_RELEASE;
                end
            end
            ST_WAIT: begin
                if (proc_done) begin
                    result_next = proc_ok;
                    state_next  = ST_RELEASE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    result_next = 1'b0;
                    state_next  = ST_RELEASE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_RELEASE: begin
                release_ok   = result_reg;
                release_fail = ~result_reg;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            car_q_reg     <= '0;
            armed_reg     <= 1'b0;
            pending_reg   <= '0;
            rr_ptr_reg    <= '0;
            proc_lane_reg <= '0;
            proc_tag_reg  <= '0;
            timer_reg     <= '0;
            result_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            car_q_reg   <= car;
            armed_reg   <= 1'b1;
            pending_reg <= pending_next;
            timer_reg   <= timer_next;
            result_reg  <= result_next;
            if (grant_take) begin
                proc_lane_reg <= grant_idx;
                proc_tag_reg  <= hipass[grant_idx*TAG_W +: TAG_W];
                rr_ptr_reg    <= grant_idx;
            end
        end
    end

    // Per-lane gate timer and sticky alarm. Both are applied on the edge
    // that leaves RELEASE, addressed by the lane still held in proc_lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [GW-1:0] gate_cnt_reg;
        logic          alarm_bit_reg;
        logic          lane_hit;

        assign lane_hit = (proc_lane_reg == IW'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                gate_cnt_reg <= '0;
            end else if (release_ok && lane_hit) begin
                // Reloading an open gate extends it without a gap.
                gate_cnt_reg <= GW'(GATE_CYCLES);
            end else if (gate_cnt_reg != '0) begin
                gate_cnt_reg <= gate_cnt_reg - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                alarm_bit_reg <= 1'b0;
            end else if (release_fail && lane_hit) begin
                alarm_bit_reg <= 1'b1;
            end else if (alarm_clr[gi]) begin
                alarm_bit_reg <= 1'b0;
            end
        end

        assign gate_open[gi] = (gate_cnt_reg != '0);
        assign alarm[gi]     = alarm_bit_reg;
    end

    assign proc_lane    = proc_lane_reg;
    assign proc_tag     = proc_tag_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign currentstate = state_reg;

endmodule

// File: tb/tb_toll_lane_scheduler.sv
// Directed testbench for toll_lane_scheduler (LANES=4, TAG_W=5,
// GATE_CYCLES=8, TIMEOUT=16). Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point, so every check sees the
// registers updated by the edge just passed.
module tb_toll_lane_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  car;
    logic [19:0] hipass;
    logic        proc_start;
    logic [1:0]  proc_lane;
    logic [4:0]  proc_tag;
    logic        proc_done;
    logic        proc_ok;
    logic [3:0]  gate_open;
    logic [3:0]  alarm;
    logic [3:0]  alarm_clr;
    logic        busy;
    logic [1:0]  currentstate;

    int checks = 0;
    int errors = 0;

    toll_lane_scheduler #(
        .LANES       (4),
        .TAG_W       (5),
        .GATE_CYCLES (8),
        .TIMEOUT     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .car          (car),
        .hipass       (hipass),
        .proc_start   (proc_start),
        .proc_lane    (proc_lane),
        .proc_tag     (proc_tag),
        .proc_done    (proc_done),
        .proc_ok      (proc_ok),
        .gate_open    (gate_open),
        .alarm        (alarm),
        .alarm_clr    (alarm_clr),
        .busy         (busy),
        .currentstate (currentstate)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_tag(input int lane, input logic [4:0] v);
        hipass[lane*5 +: 5] = v;
    endtask

    // Waits (bounded) for the next proc_start, checks the grant, answers
    // with a verdict 'delay' cycles into WAIT and returns in the IDLE cycle
    // right after RELEASE.
    task automatic serve(input int exp_lane, input int exp_tag, input int delay, input logic ok);
        int n = 0;
        while (proc_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk($sformatf("start_seen_l%0d", exp_lane), proc_start, 1);
        chk($sformatf("grant_lane_l%0d", exp_lane), proc_lane, exp_lane);
        chk($sformatf("grant_tag_l%0d", exp_lane), proc_tag, exp_tag);
        tick();
        repeat (delay) tick();
        proc_done = 1'b1;
        proc_ok   = ok;
        tick();
        proc_done = 1'b0;
        proc_ok   = 1'b0;
        chk($sformatf("release_l%0d", exp_lane), currentstate, 3);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        car       = 4'b1111;
        hipass    = '0;
        proc_done = 1'b0;
        proc_ok   = 1'b0;
        alarm_clr = '0;

        // Reset with every car present.
        tick();
        tick();
        chk("rst_state", currentstate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", proc_start, 0);
        chk("rst_lane", proc_lane, 0);
        chk("rst_tag", proc_tag, 0);
        chk("rst_gate", gate_open, 0);
        chk("rst_alarm", alarm, 0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("held_car_no_grant", busy, 0);
        car = 4'b0000;
        tick();
        tick();

        // Single lane 1, verdict ok three cycles after proc_start.
        set_tag(1, 5'd15);
        car = 4'b0010;
        tick();
        chk("e0_still_idle", currentstate, 0);
        tick();
        chk("e1_grant_state", currentstate, 1);
        chk("e1_start", proc_start, 1);
        chk("e1_lane", proc_lane, 1);
        chk("e1_tag", proc_tag, 15);
        tick();
        chk("e2_start_one_pulse", proc_start, 0);
        chk("e2_wait", currentstate, 2);
        tick();
        tick();
        proc_done = 1'b1;
        proc_ok   = 1'b1;
        tick();
        proc_done = 1'b0;
        proc_ok   = 1'b0;
        chk("ed_release", currentstate, 3);
        chk("ed_gate_closed", gate_open, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("gate1_open_c%0d", k), gate_open, 4'b0010);
            tick();
        end
        chk("gate1_closed_after_8", gate_open, 0);
        chk("single_alarm", alarm, 0);

        // Timeout on lane 3, then a stray proc_done in IDLE.
        set_tag(3, 5'd7);
        car = 4'b1000;
        tick();
        tick();
        chk("to_lane", proc_lane, 3);
        tick();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("to_wait_c%0d", k), currentstate, 2);
            tick();
        end
        chk("to_release", currentstate, 3);
        tick();
        chk("to_alarm", alarm, 4'b1000);
        chk("to_idle", currentstate, 0);
        proc_done = 1'b1;
        proc_ok   = 1'b1;
        tick();
        proc_done = 1'b0;
        proc_ok   = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_gate", gate_open, 0);
        tick();
        chk("stray_state", currentstate, 0);
        alarm_clr = 4'b1000;
        tick();
        alarm_clr = 4'b0000;
        chk("to_alarm_clr", alarm, 0);

        // Round-robin: rr_ptr is 3, lanes 0,2,3 rise together.
        set_tag(0, 5'd1);
        set_tag(2, 5'd2);
        set_tag(3, 5'd3);
        car = 4'b0000;
        tick();
        car = 4'b1101;
        tick();
        serve(0, 1, 0, 1'b1);
        serve(2, 2, 2, 1'b1);
        serve(3, 3, 0, 1'b1);
        car = 4'b0000;
        tick();
        car = 4'b1001;
        tick();
        serve(0, 1, 0, 1'b1);
        serve(3, 3, 0, 1'b1);
        chk("rr_gate3_open", gate_open[3], 1);

        // Zero tag on lane 2.
        set_tag(2, 5'd0);
        car = 4'b0000;
        tick();
        car = 4'b0100;
        tick();
        tick();
        chk("zt_grant_state", currentstate, 1);
        chk("zt_no_start", proc_start, 0);
        chk("zt_lane", proc_lane, 2);
        tick();
        chk("zt_release", currentstate, 3);
        chk("zt_alarm_not_yet", alarm[2], 0);
        tick();
        chk("zt_alarm_set", alarm[2], 1);
        chk("zt_idle", currentstate, 0);
        alarm_clr = 4'b0100;
        tick();
        alarm_clr = 4'b0000;
        chk("zt_alarm_clr", alarm[2], 0);

        // Reset during WAIT with an open gate and a pending lane (rr_ptr 2).
        set_tag(1, 5'd15);
        set_tag(2, 5'd2);
        car = 4'b0000;
        tick();
        car = 4'b1110;
        tick();
        serve(3, 3, 0, 1'b1);
        chk("mr_gate3_open", gate_open[3], 1);
        tick();
        chk("mr_lane1", proc_lane, 1);
        tick();
        chk("mr_wait", currentstate, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_state", currentstate, 0);
        chk("mr_gate", gate_open, 0);
        chk("mr_lane", proc_lane, 0);
        chk("mr_tag", proc_tag, 0);
        chk("mr_alarm", alarm, 0);
        tick();
        tick();
        tick();
        chk("mr_pending_lost", busy, 0);

        // Rise on lane 0 coincident with its own grant (rr_ptr 0).
        set_tag(0, 5'd1);
        car = 4'b0000;
        tick();
        car = 4'b0011;
        tick();
        car = 4'b0010;
        serve(1, 15, 1, 1'b1);
        car = 4'b0011;
        serve(0, 1, 0, 1'b1);
        serve(0, 1, 0, 1'b0);
        chk("sim_alarm0", alarm, 4'b0001);
        car = 4'b0000;
        tick();
        tick();
        tick();
        chk("sim_drained", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
